// File: rtl/sysid_chk_pkg.sv
// rtl/sysid_chk_pkg.sv - shared encodings and compare helper for the sysid checker
package sysid_chk_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_ID = 3'd1,
    S_WT_ID = 3'd2,
    S_RD_TS = 3'd3,
    S_WT_TS = 3'd4,
    S_CMP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_IDMM = 2'd1,
    ST_TSMM = 2'd2,
    ST_TMO  = 2'd3
  } status_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  function automatic logic is_xfer(input state_t s);
    return (s == S_RD_ID) || (s == S_WT_ID) || (s == S_RD_TS) || (s == S_WT_TS);
  endfunction

  // An ID mismatch outranks a timestamp mismatch.
  function automatic status_t cmp_status(input logic [31:0] id, input logic [31:0] ts,
                                         input logic [31:0] exp_id, input logic [31:0] exp_ts,
                                         input logic check_ts);
    if (id != exp_id) return ST_IDMM;
    if (check_ts && (ts != exp_ts)) return ST_TSMM;
    return ST_PASS;
  endfunction

endpackage

// File: rtl/niosii_system_sysid_checker_if.sv
// rtl/niosii_system_sysid_checker_if.sv - Avalon-MM read bus between checker and sysid slave
interface niosii_system_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdatavalid, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdatavalid, avm_readdata
  );
endinterface

// File: rtl/sysid_chk_timer.sv
// rtl/sysid_chk_timer.sv - 16-bit clear/enable counter with terminal-count flag
module sysid_chk_timer #(
  parameter logic [15:0] TERMINAL = 16'd255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [15:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 16'd0;
    end else if (clr) begin
      cnt <= 16'd0;
    end else if (en && !tc) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tc = (cnt == TERMINAL);
endmodule

// File: rtl/niosii_system_sysid_checker.sv
// rtl/niosii_system_sysid_checker.sv - reads sysid ID and timestamp, reports pass/mismatch/timeout
module niosii_system_sysid_checker
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h58DB_FC3D,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  niosii_system_sysid_checker_if.master avm,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic [1:0]  status,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);
  state_t  state, state_nx;
  status_t fin_st;
  logic    kick, rd, addr, cap_id, cap_ts, tmr_clr, tmr_tc, fin, clr_ok, done_c;

  sysid_chk_timer #(.TERMINAL(16'(TIMEOUT_CYCLES))) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .en      (is_xfer(state)),
    .tc      (tmr_tc)
  );

  // kick carries the auto-start after reset and a start raised during the done cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      kick  <= AUTO_START;
    end else begin
      state <= state_nx;
      kick  <= start && done_c;
    end
  end

  always_comb begin
    state_nx = state;
    rd       = 1'b0;
    addr     = ADDR_ID;
    cap_id   = 1'b0;
    cap_ts   = 1'b0;
    tmr_clr  = 1'b0;
    fin      = 1'b0;
    fin_st   = ST_PASS;
    clr_ok   = 1'b0;
    done_c   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start || kick) begin
          state_nx = S_RD_ID;
          tmr_clr  = 1'b1;
          clr_ok   = 1'b1;
        end
      end
      S_RD_ID: begin
        rd = 1'b1;
        if (!avm.avm_waitrequest) begin
          if (avm.avm_readdatavalid) begin
            cap_id   = 1'b1;
            tmr_clr  = 1'b1;
            state_nx = S_RD_TS;
          end else begin
            state_nx = S_WT_ID;
          end
        end
      end
      S_WT_ID: begin
        if (avm.avm_readdatavalid) begin
          cap_id   = 1'b1;
          tmr_clr  = 1'b1;
          state_nx = S_RD_TS;
        end
      end
      S_RD_TS: begin
        rd   = 1'b1;
        addr = ADDR_TS;
        if (!avm.avm_waitrequest) begin
          if (avm.avm_readdatavalid) begin
            cap_ts   = 1'b1;
            state_nx = S_CMP;
          end else begin
            state_nx = S_WT_TS;
          end
        end
      end
      S_WT_TS: begin
        addr = ADDR_TS;
        if (avm.avm_readdatavalid) begin
          cap_ts   = 1'b1;
          state_nx = S_CMP;
        end
      end
      S_CMP: begin
        done_c   = 1'b1;
        fin      = 1'b1;
        fin_st   = cmp_status(captured_id, captured_ts, EXPECTED_ID, EXPECTED_TS, CHECK_TS);
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Timeout overrides any acceptance or data arriving in the same cycle.
    if (is_xfer(state) && tmr_tc) begin
      rd       = 1'b0;
      cap_id   = 1'b0;
      cap_ts   = 1'b0;
      tmr_clr  = 1'b0;
      done_c   = 1'b1;
      fin      = 1'b1;
      fin_st   = ST_TMO;
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
      status      <= 2'd0;
      id_ok       <= 1'b0;
    end else begin
      if (cap_id) captured_id <= avm.avm_readdata;
      if (cap_ts) captured_ts <= avm.avm_readdata;
      if (fin) begin
        status <= fin_st;
        id_ok  <= (fin_st == ST_PASS);
      end else if (clr_ok) begin
        id_ok <= 1'b0;
      end
    end
  end

  assign avm.avm_read    = rd;
  assign avm.avm_address = addr;
  assign busy            = (state != S_IDLE);
  assign done            = done_c;
endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// tb/tb_niosii_system_sysid_checker.sv - directed vector bench for two checker configurations
module tb_niosii_system_sysid_checker;
  localparam logic [31:0] TS = 32'h58DB_FC3D;

  logic clock, reset_n, start;
  logic        busy_v [2];
  logic        done_v [2];
  logic        ok_v   [2];
  logic [1:0]  st_v   [2];
  logic [31:0] cid_v  [2];
  logic [31:0] cts_v  [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] cfg_id, cfg_ts;
  int          cfg_wait;
  logic        cfg_same, cfg_valid, late_valid;

  niosii_system_sysid_checker_if bus0 ();
  niosii_system_sysid_checker_if bus1 ();

  niosii_system_sysid_checker dut0 (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(bus0),
    .busy(busy_v[0]), .done(done_v[0]), .id_ok(ok_v[0]), .status(st_v[0]),
    .captured_id(cid_v[0]), .captured_ts(cts_v[0])
  );

  niosii_system_sysid_checker #(.CHECK_TS(1'b0), .TIMEOUT_CYCLES(8)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(bus1),
    .busy(busy_v[1]), .done(done_v[1]), .id_ok(ok_v[1]), .status(st_v[1]),
    .captured_id(cid_v[1]), .captured_ts(cts_v[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave models: cfg_wait stall cycles per read, data next cycle or with the accept.
  int wc0 = 0, wc1 = 0;
  logic pend0 = 1'b0, pend1 = 1'b0;
  logic [31:0] pd0 = 32'd0, pd1 = 32'd0;
  logic acc0, acc1;
  logic [31:0] word0, word1;

  assign bus0.avm_waitrequest   = bus0.avm_read && (wc0 < cfg_wait);
  assign acc0                   = bus0.avm_read && !bus0.avm_waitrequest;
  assign word0                  = bus0.avm_address ? cfg_ts : cfg_id;
  assign bus0.avm_readdatavalid = late_valid || (cfg_same ? (acc0 && cfg_valid) : pend0);
  assign bus0.avm_readdata      = late_valid ? 32'hDEAD_BEEF : (cfg_same ? word0 : pd0);
  always @(posedge clock) begin
    wc0   <= (acc0 || !bus0.avm_read) ? 0 : wc0 + 1;
    pend0 <= acc0 && cfg_valid && !cfg_same;
    if (acc0) pd0 <= word0;
  end

  assign bus1.avm_waitrequest   = bus1.avm_read && (wc1 < cfg_wait);
  assign acc1                   = bus1.avm_read && !bus1.avm_waitrequest;
  assign word1                  = bus1.avm_address ? cfg_ts : cfg_id;
  assign bus1.avm_readdatavalid = late_valid || (cfg_same ? (acc1 && cfg_valid) : pend1);
  assign bus1.avm_readdata      = late_valid ? 32'hDEAD_BEEF : (cfg_same ? word1 : pd1);
  always @(posedge clock) begin
    wc1   <= (acc1 || !bus1.avm_read) ? 0 : wc1 + 1;
    pend1 <= acc1 && cfg_valid && !cfg_same;
    if (acc1) pd1 <= word1;
  end

  int nd0 = 0, nd1 = 0;
  always @(negedge clock) begin
    if (done_v[0]) nd0 <= nd0 + 1;
    if (done_v[1]) nd1 <= nd1 + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stalled request must hold read and address until accepted.
  logic hold_p = 1'b0, addr_p = 1'b0;
  always @(negedge clock) begin
    if (hold_p && reset_n) begin
      chk("hold_read", 32'(bus0.avm_read), 32'd1);
      chk("hold_addr", 32'(bus0.avm_address), 32'(addr_p));
    end
    hold_p <= bus0.avm_read && bus0.avm_waitrequest;
    addr_p <= bus0.avm_address;
  end

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] ts;
    logic [7:0]  wt;
    logic        same;
    logic [1:0]  st0;
    logic [1:0]  st1;
  } vec_t;

  vec_t vecs [11];

  task automatic wait_idle(input string nm);
    int k = 0;
    while ((busy_v[0] || busy_v[1]) && k < 1000) begin
      @(negedge clock);
      k++;
    end
    chk({nm, "_bound"}, 32'(k < 1000), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic set_cfg(input logic [31:0] id, input logic [31:0] ts, input int wt, input logic same);
    cfg_id = id; cfg_ts = ts; cfg_wait = wt; cfg_same = same; cfg_valid = 1'b1;
  endtask

  task automatic release_check(input string tag);
    int n = 0;
    @(negedge clock);
    reset_n = 1'b1;
    while (!done_v[0] && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd5);
    chk({tag, "_done1"}, 32'(done_v[1]), 32'd1);
    wait_idle(tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_st%0d", tag, i), 32'(st_v[i]), 32'd0);
      chk($sformatf("%s_ok%0d", tag, i), 32'(ok_v[i]), 32'd1);
      chk($sformatf("%s_cid%0d", tag, i), cid_v[i], 32'd0);
      chk($sformatf("%s_cts%0d", tag, i), cts_v[i], TS);
    end
  endtask

  initial begin
    int n, t0, t1, d0, d1;
    logic [31:0] keep_id;

    vecs[0]  = '{32'h0000_0000, TS,           8'd0,  1'b0, 2'd0, 2'd0};
    vecs[1]  = '{32'h0000_0001, TS,           8'd0,  1'b0, 2'd1, 2'd1};
    vecs[2]  = '{32'h0000_0000, 32'h58DBFC3E, 8'd0,  1'b0, 2'd2, 2'd0};
    vecs[3]  = '{32'h0000_0000, TS,           8'd10, 1'b0, 2'd0, 2'd3};
    vecs[4]  = '{32'h0000_0000, TS,           8'd0,  1'b1, 2'd0, 2'd0};
    vecs[5]  = '{32'hFFFF_FFFF, TS,           8'd3,  1'b1, 2'd1, 2'd1};
    vecs[6]  = '{32'h0000_0000, TS,           8'd6,  1'b0, 2'd0, 2'd0};
    vecs[7]  = '{32'h0000_0000, TS,           8'd7,  1'b0, 2'd0, 2'd3};
    vecs[8]  = '{32'h0000_0000, TS,           8'd7,  1'b1, 2'd0, 2'd0};
    vecs[9]  = '{32'h0000_0000, TS,           8'd8,  1'b1, 2'd0, 2'd3};
    vecs[10] = '{32'h0000_0005, 32'h0,        8'd0,  1'b0, 2'd1, 2'd1};

    reset_n = 1'b0; start = 1'b0; late_valid = 1'b0;
    set_cfg(32'h0, TS, 0, 1'b0);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(done_v[i]), 32'd0);
      chk($sformatf("rst_ok%0d", i), 32'(ok_v[i]), 32'd0);
      chk($sformatf("rst_st%0d", i), 32'(st_v[i]), 32'd0);
      chk($sformatf("rst_cid%0d", i), cid_v[i], 32'd0);
      chk($sformatf("rst_cts%0d", i), cts_v[i], 32'd0);
    end
    chk("rst_read", 32'(bus0.avm_read), 32'd0);
    chk("rst_addr", 32'(bus0.avm_address), 32'd0);

    release_check("auto");

    for (int i = 0; i < 11; i++) begin
      set_cfg(vecs[i].id, vecs[i].ts, int'(vecs[i].wt), vecs[i].same);
      d0 = nd0; d1 = nd1;
      pulse_start();
      wait_idle($sformatf("v%0d", i));
      chk($sformatf("v%0d_st0", i), 32'(st_v[0]), 32'(vecs[i].st0));
      chk($sformatf("v%0d_st1", i), 32'(st_v[1]), 32'(vecs[i].st1));
      chk($sformatf("v%0d_ok0", i), 32'(ok_v[0]), 32'(vecs[i].st0 == 2'd0));
      chk($sformatf("v%0d_ok1", i), 32'(ok_v[1]), 32'(vecs[i].st1 == 2'd0));
      chk($sformatf("v%0d_cid0", i), cid_v[0], vecs[i].id);
      chk($sformatf("v%0d_cts0", i), cts_v[0], vecs[i].ts);
      if (vecs[i].st1 != 2'd3) begin
        chk($sformatf("v%0d_cid1", i), cid_v[1], vecs[i].id);
        chk($sformatf("v%0d_cts1", i), cts_v[1], vecs[i].ts);
      end
      chk($sformatf("v%0d_ndone0", i), 32'(nd0 - d0), 32'd1);
      chk($sformatf("v%0d_ndone1", i), 32'(nd1 - d1), 32'd1);
    end

    // No data ever returned: timeout after TIMEOUT_CYCLES, late valid ignored, retry.
    set_cfg(32'h0, TS, 0, 1'b0);
    cfg_valid = 1'b0;
    pulse_start();
    n = 1; t0 = 0; t1 = 0;
    while ((t0 == 0 || t1 == 0) && n < 400) begin
      if (done_v[0] && t0 == 0) t0 = n;
      if (done_v[1] && t1 == 0) t1 = n;
      @(negedge clock);
      n++;
    end
    chk("tmo_cycles0", 32'(t0), 32'd256);
    chk("tmo_cycles1", 32'(t1), 32'd9);
    wait_idle("tmo");
    chk("tmo_st0", 32'(st_v[0]), 32'd3);
    chk("tmo_ok0", 32'(ok_v[0]), 32'd0);
    keep_id = cid_v[0];
    d0 = nd0;
    late_valid = 1'b1;
    @(negedge clock);
    late_valid = 1'b0;
    @(negedge clock);
    chk("late_busy", 32'(busy_v[0]), 32'd0);
    chk("late_cid", cid_v[0], keep_id);
    chk("late_ndone", 32'(nd0 - d0), 32'd0);
    cfg_valid = 1'b1;
    pulse_start();
    wait_idle("retry");
    chk("retry_st0", 32'(st_v[0]), 32'd0);
    chk("retry_ok0", 32'(ok_v[0]), 32'd1);

    // Start raised in the done cycle launches the next check.
    d0 = nd0;
    pulse_start();
    n = 0;
    while (!done_v[0] && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("b2b_first", 32'(done_v[0]), 32'd1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    while (!done_v[0] && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("b2b_latency", 32'(n), 32'd6);
    wait_idle("b2b");
    chk("b2b_ndone", 32'(nd0 - d0), 32'd2);
    chk("b2b_st0", 32'(st_v[0]), 32'd0);

    // Asynchronous reset while waiting for the timestamp word.
    pulse_start();
    repeat (3) @(negedge clock);
    chk("mid_addr_ts", 32'(bus0.avm_address), 32'd1);
    chk("mid_busy_pre", 32'(busy_v[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy_v[0]), 32'd0);
    chk("mid_read", 32'(bus0.avm_read), 32'd0);
    chk("mid_addr", 32'(bus0.avm_address), 32'd0);
    chk("mid_cid", cid_v[0], 32'd0);
    chk("mid_cts", cts_v[0], 32'd0);
    chk("mid_ok", 32'(ok_v[0]), 32'd0);
    release_check("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
